// File: rtl/rc4_key_search_ctrl_if.sv
// Phase handshakes and S-RAM port bundle for the RC4 key search sequencer.
// master = sequencer side, slave = sub-block / RAM side.
interface rc4_key_search_ctrl_if;
  logic       init_start;
  logic       init_done;
  logic [7:0] init_addr;
  logic [7:0] init_data;
  logic       init_wren;

  logic       scr_start;
  logic       scr_done;
  logic [7:0] scr_addr;
  logic [7:0] scr_data;
  logic       scr_wren;

  logic       dec_start;
  logic       dec_done;
  logic       dec_match;
  logic [7:0] dec_addr;
  logic [7:0] dec_data;
  logic       dec_wren;

  logic [7:0] s_address;
  logic [7:0] s_data;
  logic       s_wren;

  modport master (
    output init_start, scr_start, dec_start,
    output s_address, s_data, s_wren,
    input  init_done, scr_done, dec_done, dec_match,
    input  init_addr, init_data, init_wren,
    input  scr_addr, scr_data, scr_wren,
    input  dec_addr, dec_data, dec_wren
  );

  modport slave (
    input  init_start, scr_start, dec_start,
    input  s_address, s_data, s_wren,
    output init_done, scr_done, dec_done, dec_match,
    output init_addr, init_data, init_wren,
    output scr_addr, scr_data, scr_wren,
    output dec_addr, dec_data, dec_wren
  );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// RC4 brute-force key search sequencer: init -> scramble -> decrypt per key,
// owns the single S-RAM port and stops on match, exhaustion, watchdog or abort.
module rc4_key_search_ctrl #(
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_START = '0,
  parameter logic [KEY_W-1:0] KEY_END   = 24'h3FFFFF,
  parameter int               WDOG_CYC  = 8192
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  rc4_key_search_ctrl_if.master bus,
  output logic [KEY_W-1:0]     secret_key,
  output logic [1:0]           phase,
  output logic                 busy,
  output logic                 key_found,
  output logic                 key_failed,
  output logic                 wdog_err
);

  localparam int CW = $clog2(WDOG_CYC + 2);
  localparam bit WD_EN = (WDOG_CYC != 0);
  localparam logic [CW-1:0] WD_LAST =
    CW'((WDOG_CYC > 0) ? WDOG_CYC - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, INIT_RUN, INIT_REL, SCR_RUN, SCR_REL,
    DEC_RUN, DEC_REL, NEXT_KEY, FOUND, FAILED, ERROR
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          hit;
  logic          hit_n;
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  logic          in_run;

  assign wd_hit = WD_EN && (wd_cnt >= WD_LAST);
  assign in_run = (state == INIT_RUN) ||
                  (state == SCR_RUN)  ||
                  (state == DEC_RUN);

  always_comb begin
    state_n = state;
    hit_n   = hit;
    unique case (state)
      IDLE:     if (start) state_n = INIT_RUN;
      INIT_RUN: begin
        if (bus.init_done)  state_n = INIT_REL;
        else if (wd_hit)    state_n = ERROR;
      end
      INIT_REL: if (!bus.init_done) state_n = SCR_RUN;
      SCR_RUN:  begin
        if (bus.scr_done)   state_n = SCR_REL;
        else if (wd_hit)    state_n = ERROR;
      end
      SCR_REL:  if (!bus.scr_done) state_n = DEC_RUN;
      DEC_RUN:  begin
        if (bus.dec_done) begin
          state_n = DEC_REL;
          hit_n   = bus.dec_match;
        end else if (wd_hit) begin
          state_n = ERROR;
        end
      end
      DEC_REL:  begin
        if (!bus.dec_done)
          state_n = hit ? FOUND : NEXT_KEY;
      end
      NEXT_KEY: begin
        state_n = (secret_key == KEY_END) ? FAILED : INIT_RUN;
      end
      FOUND, FAILED, ERROR: if (!start) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      hit            <= 1'b0;
      wd_cnt         <= '0;
      secret_key     <= KEY_START;
      bus.init_start <= 1'b0;
      bus.scr_start  <= 1'b0;
      bus.dec_start  <= 1'b0;
      phase          <= 2'd0;
      busy           <= 1'b0;
      key_found      <= 1'b0;
      key_failed     <= 1'b0;
      wdog_err       <= 1'b0;
    end else begin
      state <= state_n;
      hit   <= hit_n;
      // counter restarts on every state change, so each RUN entry sees 0
      if (state_n != state)
        wd_cnt <= '0;
      else if (in_run && wd_cnt < WD_LAST)
        wd_cnt <= wd_cnt + CW'(1);
      if (state == IDLE && state_n == INIT_RUN)
        secret_key <= KEY_START;
      else if (state == NEXT_KEY && state_n == INIT_RUN)
        secret_key <= secret_key + KEY_W'(1);
      bus.init_start <= (state_n == INIT_RUN);
      bus.scr_start  <= (state_n == SCR_RUN);
      bus.dec_start  <= (state_n == DEC_RUN);
      unique case (state_n)
        INIT_RUN, INIT_REL: phase <= 2'd1;
        SCR_RUN, SCR_REL:   phase <= 2'd2;
        DEC_RUN, DEC_REL:   phase <= 2'd3;
        default:            phase <= 2'd0;
      endcase
      busy <= !((state_n == IDLE)   || (state_n == FOUND) ||
                (state_n == FAILED) || (state_n == ERROR));
      key_found  <= (state_n == FOUND);
      key_failed <= (state_n == FAILED);
      wdog_err   <= (state_n == ERROR);
    end
  end

  always_comb begin
    bus.s_address = 8'd0;
    bus.s_data    = 8'd0;
    bus.s_wren    = 1'b0;
    unique case (phase)
      2'd1: begin
        bus.s_address = bus.init_addr;
        bus.s_data    = bus.init_data;
        bus.s_wren    = bus.init_wren;
      end
      2'd2: begin
        bus.s_address = bus.scr_addr;
        bus.s_data    = bus.scr_data;
        bus.s_wren    = bus.scr_wren;
      end
      2'd3: begin
        bus.s_address = bus.dec_addr;
        bus.s_data    = bus.dec_data;
        bus.s_wren    = bus.dec_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with small behavioural sub-block
// models; keys 0..3, watchdog 16.
module tb_rc4_key_search_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [23:0] secret_key;
  logic [1:0]  phase;
  logic        busy;
  logic        key_found;
  logic        key_failed;
  logic        wdog_err;

  logic       init_m, scr_m, dec_m;
  logic [2:0] ic, sc, dc;
  logic       init_hold, scr_hang, match_en;
  logic [23:0] match_key;
  logic       init_wren_v, scr_wren_v;
  logic       is_q, ss_q, ds_q;
  int         log_q[$];
  int         exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n;

  rc4_key_search_ctrl_if bus ();

  rc4_key_search_ctrl #(
    .KEY_W(24), .KEY_START(24'd0), .KEY_END(24'd3), .WDOG_CYC(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .bus(bus), .secret_key(secret_key), .phase(phase),
    .busy(busy), .key_found(key_found), .key_failed(key_failed),
    .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  assign bus.init_done = init_m | init_hold;
  assign bus.scr_done  = scr_m;
  assign bus.dec_done  = dec_m;
  assign bus.dec_match = dec_m & match_en & (secret_key == match_key);
  assign bus.init_addr = 8'h11;
  assign bus.init_data = 8'h22;
  assign bus.init_wren = init_wren_v;
  assign bus.scr_addr  = 8'h33;
  assign bus.scr_data  = 8'h44;
  assign bus.scr_wren  = scr_wren_v;
  assign bus.dec_addr  = 8'h55;
  assign bus.dec_data  = 8'h66;
  assign bus.dec_wren  = 1'b1;

  always @(posedge clk) begin
    if (reset || !bus.init_start) begin
      ic <= 3'd0; init_m <= 1'b0;
    end else if (ic == 3'd3) init_m <= 1'b1;
    else ic <= ic + 3'd1;
  end

  always @(posedge clk) begin
    if (reset || !bus.scr_start) begin
      sc <= 3'd0; scr_m <= 1'b0;
    end else if (sc == 3'd3) scr_m <= !scr_hang;
    else sc <= sc + 3'd1;
  end

  always @(posedge clk) begin
    if (reset || !bus.dec_start) begin
      dc <= 3'd0; dec_m <= 1'b0;
    end else if (dc == 3'd3) dec_m <= 1'b1;
    else dc <= dc + 3'd1;
  end

  always @(negedge clk) begin
    if (bus.init_start && !is_q) log_q.push_back(256 + int'(secret_key[7:0]));
    if (bus.scr_start && !ss_q)  log_q.push_back(512 + int'(secret_key[7:0]));
    if (bus.dec_start && !ds_q)  log_q.push_back(768 + int'(secret_key[7:0]));
    is_q <= bus.init_start;
    ss_q <= bus.scr_start;
    ds_q <= bus.dec_start;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input int nkeys);
    exp_q.delete();
    for (int k = 0; k < nkeys; k++) begin
      exp_q.push_back(256 + k);
      exp_q.push_back(512 + k);
      exp_q.push_back(768 + k);
    end
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(tag, log_q[i], exp_q[i]);
  endtask

  task automatic stop_run();
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    init_hold = 1'b0; scr_hang = 1'b0; match_en = 1'b0;
    match_key = 24'd0; init_wren_v = 1'b1; scr_wren_v = 1'b0;
    is_q = 1'b0; ss_q = 1'b0; ds_q = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_phase", phase, 0);
    chk("rst_starts", {bus.init_start, bus.scr_start, bus.dec_start}, 0);
    chk("rst_flags", {key_found, key_failed, wdog_err}, 0);
    chk("rst_key", secret_key, 0);
    chk("rst_s_wren", bus.s_wren, 0);
    chk("rst_s_addr", bus.s_address, 0);
    @(negedge clk);
    reset = 1'b0;

    // key 2 matches
    log_q.delete();
    match_en = 1'b1; match_key = 24'd2; start = 1'b1;
    for (n = 0; n < 500 && phase != 2'd2; n++) @(negedge clk);
    chk("scr_tmo", n < 500, 1);
    chk("mux_scr_addr", bus.s_address, 8'h33);
    chk("mux_scr_data", bus.s_data, 8'h44);
    chk("mux_scr_wren0", bus.s_wren, 0);
    scr_wren_v = 1'b1;
    #1;
    chk("mux_scr_wren1", bus.s_wren, 1);
    scr_wren_v = 1'b0;
    for (n = 0; n < 500 && phase != 2'd3; n++) @(negedge clk);
    chk("dec_tmo", n < 500, 1);
    chk("mux_dec_addr", bus.s_address, 8'h55);
    chk("mux_dec_data", bus.s_data, 8'h66);
    for (n = 0; n < 2000 && !key_found; n++) @(negedge clk);
    chk("found_tmo", n < 2000, 1);
    chk("found_key", secret_key, 2);
    chk("found_busy", busy, 0);
    chk("found_phase", phase, 0);
    chk("found_starts", {bus.init_start, bus.scr_start, bus.dec_start}, 0);
    build_exp(3);
    chk_log("order_hit");
    repeat (3) @(negedge clk);
    chk("found_hold", key_found, 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("found_idle", key_found, 0);

    // no match: all four keys then FAILED
    @(negedge clk);
    log_q.delete();
    match_en = 1'b0; start = 1'b1;
    for (n = 0; n < 2000 && !key_failed; n++) @(negedge clk);
    chk("fail_tmo", n < 2000, 1);
    chk("fail_key", secret_key, 3);
    chk("fail_flags", {key_found, wdog_err, busy}, 0);
    build_exp(4);
    chk_log("order_miss");
    start = 1'b0;
    @(posedge clk); #1;
    chk("fail_idle", {key_failed, busy, phase}, 0);

    // scramble never completes
    @(negedge clk);
    scr_hang = 1'b1; start = 1'b1;
    for (n = 0; n < 500 && !bus.scr_start; n++) @(negedge clk);
    chk("wd_scr_tmo", n < 500, 1);
    for (n = 0; n < 100 && !wdog_err; n++) @(negedge clk);
    chk("wd_cycles", n, 16);
    chk("wd_err", wdog_err, 1);
    chk("wd_outs", {busy, phase, bus.scr_start}, 0);
    start = 1'b0; scr_hang = 1'b0;
    @(posedge clk); #1;
    chk("wd_idle", wdog_err, 0);

    // abort during key 1 decrypt
    @(negedge clk);
    start = 1'b1;
    for (n = 0; n < 500 && !(bus.dec_start && secret_key == 24'd1); n++)
      @(negedge clk);
    chk("ab_tmo", n < 500, 1);
    abort = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    chk("ab_dec_start", bus.dec_start, 0);
    chk("ab_phase", phase, 0);
    chk("ab_busy", busy, 0);
    chk("ab_key_kept", secret_key, 1);
    @(negedge clk);
    abort = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("ab_restart_init", bus.init_start, 1);
    chk("ab_restart_key", secret_key, 0);
    stop_run();

    // sync reset during key 1 scramble, stale init_done afterwards
    start = 1'b1;
    for (n = 0; n < 500 && !(bus.scr_start && secret_key == 24'd1); n++)
      @(negedge clk);
    chk("rs_tmo", n < 500, 1);
    reset = 1'b1; init_hold = 1'b1;
    @(posedge clk); #1;
    chk("rs_outs", {busy, phase, bus.scr_start, key_found, key_failed, wdog_err}, 0);
    chk("rs_key", secret_key, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rs_init_run", bus.init_start, 1);
    @(posedge clk); #1;
    chk("rs_init_rel", {bus.init_start, phase}, 2'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("rs_held", {bus.scr_start, phase}, 2'd1);
    @(negedge clk);
    init_hold = 1'b0;
    @(posedge clk); #1;
    chk("rs_scr_run", {bus.scr_start, phase}, 3'b110);
    stop_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
